// File: rtl/button_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter and its repeat timer.
package button_event_arbiter_pkg;

  // Output port handshake FSM.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } out_state_e;

  // Hold-to-repeat timer FSM.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HOLD = 2'd1,
    R_RPT  = 2'd2
  } rpt_state_e;

  // Larger of two integers; sizes the repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Hold-to-repeat timer: follows the most recently pressed button and emits
// one-cycle repeat strobes after an initial hold delay, then at a fixed period.
module hold_repeat_timer
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int RPT_CYCLES  = 10000000,
  parameter int RPT_EN      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] set_edge,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] set_rpt
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, RPT_CYCLES));
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  hold_id_q, hold_id_d;
  logic [ID_W-1:0]  first_id;
  logic             start;
  logic             held;

  // Lowest-index button among this cycle's presses becomes the new hold target.
  always_comb begin
    first_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (set_edge[i]) first_id = ID_W'(i);
    end
  end

  // Next-state, counter and repeat strobe; with repeat disabled the FSM never leaves R_IDLE.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hold_id_d = hold_id_q;
    set_rpt   = '0;
    start     = (RPT_EN != 0) && (|set_edge);
    held      = btn_in[hold_id_q];
    if (start) begin
      // A new press always retargets the timer, even mid-repeat.
      hold_id_d = first_id;
      count_d   = '0;
      state_d   = R_HOLD;
    end else begin
      case (state_q)
        R_HOLD: begin
          if (!held) begin
            state_d = R_IDLE;
            count_d = '0;
          end else if (count_q == HOLD_LAST) begin
            set_rpt[hold_id_q] = 1'b1;
            count_d            = '0;
            state_d            = R_RPT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        R_RPT: begin
          if (!held) begin
            state_d = R_IDLE;
            count_d = '0;
          end else if (count_q == RPT_LAST) begin
            set_rpt[hold_id_q] = 1'b1;
            count_d            = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = R_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Timer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      count_q   <= '0;
      hold_id_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hold_id_q <= hold_id_d;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: converts debounced button levels into one-shot press
// and repeat events, queued one per button and shared round-robin on a
// valid/ready port. A sticky overflow flag records events lost to a full slot.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int RPT_CYCLES  = 10000000,
  parameter int RPT_EN      = 1,
  localparam int ID_W       = $clog2(N_BTN)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [ID_W-1:0]  EVT_ID,
  output logic             EVT_RPT,
  output logic             OVF,
  input  logic             OVF_CLR
);

  logic [N_BTN-1:0] prev_q, prev_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] rpt_flag_q, rpt_flag_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic             evt_rpt_q, evt_rpt_d;
  logic             ovf_q, ovf_d;
  out_state_e       state_q, state_d;

  logic [N_BTN-1:0] set_edge;
  logic [N_BTN-1:0] set_rpt;
  logic [N_BTN-1:0] set_mask;
  logic [N_BTN-1:0] lost;
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] grant_mask;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic             grant_en;

  // Index base+k modulo N_BTN, for k in 1..N_BTN.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_BTN) s = s - N_BTN;
    return ID_W'(s);
  endfunction

  hold_repeat_timer #(
    .N_BTN       (N_BTN),
    .HOLD_CYCLES (HOLD_CYCLES),
    .RPT_CYCLES  (RPT_CYCLES),
    .RPT_EN      (RPT_EN)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .set_edge (set_edge),
    .btn_in   (BTN_IN),
    .set_rpt  (set_rpt)
  );

  // Rising-edge detect; releases are ignored.
  always_comb begin
    set_edge = BTN_IN & ~prev_q;
    prev_d   = BTN_IN;
  end

  // Round-robin pick: first pending index after the last grant, wrapping.
  always_comb begin
    grant_id    = last_grant_q;
    grant_found = 1'b0;
    for (int k = 1; k <= N_BTN; k++) begin
      if (!grant_found && pending_q[wrap_idx(last_grant_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_idx(last_grant_q, k);
      end
    end
    // A grant happens from IDLE, or in OFFER only on the accepting cycle.
    grant_en   = grant_found && ((state_q == IDLE) || EVT_READY);
    grant_mask = '0;
    if (grant_en) grant_mask[grant_id] = 1'b1;
  end

  // Pending slots, repeat flags and overflow; a set onto an occupied slot is dropped.
  always_comb begin
    set_mask   = set_edge | set_rpt;
    lost       = set_mask & pending_q & ~grant_mask;
    accept     = set_mask & ~lost;
    pending_d  = (pending_q & ~grant_mask) | set_mask;
    rpt_flag_d = (rpt_flag_q & ~accept) | (accept & ~set_edge);
    ovf_d      = (ovf_q & ~OVF_CLR) | (|lost);
  end

  // Output FSM: load a granted event and hold it stable until accepted.
  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    evt_rpt_d    = evt_rpt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          evt_id_d     = grant_id;
          evt_rpt_d    = rpt_flag_q[grant_id];
          last_grant_d = grant_id;
          state_d      = OFFER;
        end
      end
      OFFER: begin
        if (EVT_READY) begin
          if (grant_en) begin
            evt_id_d     = grant_id;
            evt_rpt_d    = rpt_flag_q[grant_id];
            last_grant_d = grant_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any offered or pending event.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q       <= '0;
      pending_q    <= '0;
      rpt_flag_q   <= '0;
      last_grant_q <= ID_W'(N_BTN - 1);
      evt_id_q     <= '0;
      evt_rpt_q    <= 1'b0;
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
    end else begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      rpt_flag_q   <= rpt_flag_d;
      last_grant_q <= last_grant_d;
      evt_id_q     <= evt_id_d;
      evt_rpt_q    <= evt_rpt_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
    end
  end

  assign EVT_VALID = (state_q == OFFER);
  assign EVT_ID    = evt_id_q;
  assign EVT_RPT   = evt_rpt_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter (N_BTN=4, HOLD=8, RPT=4).
module tb_button_event_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN_IN;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [1:0] EVT_ID;
  logic       EVT_RPT;
  logic       OVF;
  logic       OVF_CLR;

  button_event_arbiter #(
    .N_BTN       (4),
    .HOLD_CYCLES (8),
    .RPT_CYCLES  (4),
    .RPT_EN      (1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTN_IN    (BTN_IN),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .EVT_ID    (EVT_ID),
    .EVT_RPT   (EVT_RPT),
    .OVF       (OVF),
    .OVF_CLR   (OVF_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int rpt;
    int cyc;   // expected handshake edge index, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   c0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input int id, input int rpt, input int c);
    exp_t e;
    e.id  = id;
    e.rpt = rpt;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic score_event();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got id=%0d rpt=%0d, required no event (t=%0t)", EVT_ID, EVT_RPT, $time);
    end else begin
      e = exp_q.pop_front();
      check("evt_id", EVT_ID, e.id);
      check("evt_rpt", EVT_RPT, e.rpt);
      if (e.cyc >= 0) check("evt_cycle", cyc + 1, e.cyc);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step(1);
      n++;
    end
    check("drain_pending_expected", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST_N     = 1'b0;
    BTN_IN    = '0;
    EVT_READY = 1'b0;
    OVF_CLR   = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(1);
  endtask

  // Monitor: scores each handshake and checks offers stay stable under backpressure.
  logic       stall_prev = 1'b0;
  logic [1:0] stall_id   = '0;
  logic       stall_rpt  = 1'b0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", EVT_VALID, 1);
        check("stall_id", EVT_ID, stall_id);
        check("stall_rpt", EVT_RPT, stall_rpt);
      end
      if (EVT_VALID && EVT_READY) score_event();
      stall_prev <= EVT_VALID && !EVT_READY;
      stall_id   <= EVT_ID;
      stall_rpt  <= EVT_RPT;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before t=100000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N     = 1'b0;
    BTN_IN    = '0;
    EVT_READY = 1'b0;
    OVF_CLR   = 1'b0;
    step(3);
    check("reset_valid", EVT_VALID, 0);
    check("reset_id", EVT_ID, 0);
    check("reset_rpt", EVT_RPT, 0);
    check("reset_ovf", OVF, 0);
    RST_N = 1'b1;
    step(2);
    check("idle_valid", EVT_VALID, 0);

    // Single tap: event two edges after the rise, one cycle wide.
    EVT_READY = 1'b1;
    c0        = cyc;
    BTN_IN    = 4'b0001;
    push_exp(0, 0, c0 + 3);
    step(1);
    check("t1_valid_after_1", EVT_VALID, 0);
    step(1);
    check("t1_valid_after_2", EVT_VALID, 1);
    check("t1_id", EVT_ID, 0);
    step(1);
    check("t1_one_wide", EVT_VALID, 0);
    BTN_IN = '0;
    drain(20);
    step(12);

    // Simultaneous press 1011: round robin from last_grant=3 gives 0,1,3 back to back.
    do_reset();
    EVT_READY = 1'b1;
    c0        = cyc;
    BTN_IN    = 4'b1011;
    push_exp(0, 0, c0 + 3);
    push_exp(1, 0, c0 + 4);
    push_exp(3, 0, c0 + 5);
    step(3);
    BTN_IN = '0;
    drain(20);
    step(12);

    // Backpressure: offered event held, re-press refills the slot, third press overflows.
    do_reset();
    BTN_IN = 4'b0100;
    step(3);
    BTN_IN = '0;
    step(2);
    BTN_IN = 4'b0100;
    step(3);
    check("t3_ovf_after_repress", OVF, 0);
    check("t3_valid_held", EVT_VALID, 1);
    BTN_IN = '0;
    step(2);
    BTN_IN = 4'b0100;
    step(2);
    check("t3_ovf_set", OVF, 1);
    check("t3_valid_still", EVT_VALID, 1);
    check("t3_id_stable", EVT_ID, 2);
    BTN_IN = '0;
    step(2);
    check("t3_ovf_sticky", OVF, 1);
    OVF_CLR = 1'b1;
    step(1);
    OVF_CLR = 1'b0;
    check("t3_ovf_cleared", OVF, 0);
    c0 = cyc;
    push_exp(2, 0, c0 + 1);
    push_exp(2, 0, c0 + 2);
    EVT_READY = 1'b1;
    drain(20);
    step(12);

    // Hold btn1: press, repeats at +8,+12,+16,+20,+24, nothing after release.
    do_reset();
    EVT_READY = 1'b1;
    c0        = cyc;
    BTN_IN    = 4'b0010;
    push_exp(1, 0, c0 + 3);
    for (int k = 8; k <= 24; k += 4) push_exp(1, 1, c0 + 3 + k);
    step(26);
    BTN_IN = '0;
    drain(40);
    step(20);
    check("t4_no_ovf", OVF, 0);

    // Fairness: btn0 repeat pending alongside tapped btn3; btn3 served before the repeat.
    do_reset();
    c0     = cyc;
    BTN_IN = 4'b1001;
    step(2);
    BTN_IN = 4'b0001;
    step(8);
    push_exp(0, 0, c0 + 11);
    push_exp(3, 0, c0 + 12);
    push_exp(0, 1, c0 + 13);
    EVT_READY = 1'b1;
    step(1);
    BTN_IN = '0;
    drain(20);
    step(12);
    check("t5_no_ovf", OVF, 0);

    // Reset while offering with OVF set; btn0 held through release gives one fresh press.
    do_reset();
    BTN_IN = 4'b0001;
    step(2);
    BTN_IN = '0;
    step(2);
    BTN_IN = 4'b0001;
    step(2);
    BTN_IN = '0;
    step(2);
    BTN_IN = 4'b0001;
    step(2);
    check("t6_pre_ovf", OVF, 1);
    check("t6_pre_valid", EVT_VALID, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_async_valid", EVT_VALID, 0);
    check("t6_async_ovf", OVF, 0);
    check("t6_async_id", EVT_ID, 0);
    step(2);
    RST_N     = 1'b1;
    EVT_READY = 1'b1;
    c0        = cyc;
    push_exp(0, 0, c0 + 3);
    step(3);
    BTN_IN = '0;
    drain(20);
    step(12);
    check("t6_final_ovf", OVF, 0);
    check("t6_final_valid", EVT_VALID, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
